// File: rtl/rsa_modexp_mont.sv
`default_nettype none
// ============================================================================
// Module   : rsa_modexp_mont
// Brief    : C = M^E mod P using bit-serial Montgomery multiplication and
//            MSB-first square-and-multiply, with start/busy/done/abort.
// Revision : 1.0 - initial release
// ============================================================================
module rsa_modexp_mont #(
    parameter int WIDTH      = 8,
    parameter int CONST_TIME = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] m,
    input  logic [WIDTH-1:0] r2,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] c
);
    localparam int               c_IW  = $clog2(WIDTH);
    localparam int               c_CW  = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE_M = 3'd1,
        S_PRE_A = 3'd2,
        S_SQR   = 3'd3,
        S_MUL   = 3'd4,
        S_POST  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t           r_state;
    state_t           w_state_n;

    logic [WIDTH-1:0] r_p, r_e, r_m, r_r2;
    logic [WIDTH-1:0] r_a, r_mb;
    logic [WIDTH+1:0] r_t;
    logic [c_CW-1:0]  r_cnt;
    logic [c_IW-1:0]  r_idx;
    logic             r_busy, r_done, r_err;
    logic [WIDTH-1:0] r_c;

    logic [WIDTH-1:0] w_op_a, w_op_b, w_a_sh;
    logic             w_abit, w_last, w_ebit, w_idx_zero, w_mul_st, w_busy_n;
    logic [WIDTH+2:0] w_sum, w_odd;
    logic [WIDTH+1:0] w_t_next, w_t_sub;
    logic             w_ge;
    logic [WIDTH-1:0] w_res;
    logic             w_load, w_a_we, w_mb_we, w_idx_dec;
    logic             w_unused;

    assign busy = r_busy;
    assign done = r_done;
    assign err  = r_err;
    assign c    = r_c;

    // Multiplier operand selection: every state that multiplies picks (A, B).
    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        case (r_state)
            S_PRE_M: begin w_op_a = r_m;   w_op_b = r_r2;  end
            S_PRE_A: begin w_op_a = c_ONE; w_op_b = r_r2;  end
            S_SQR:   begin w_op_a = r_a;   w_op_b = r_a;   end
            S_MUL:   begin w_op_a = r_a;   w_op_b = r_mb;  end
            S_POST:  begin w_op_a = r_a;   w_op_b = c_ONE; end
            default: begin w_op_a = '0;    w_op_b = '0;    end
        endcase
    end

    assign w_a_sh     = w_op_a >> r_cnt;
    assign w_abit     = w_a_sh[0];
    assign w_last     = (r_cnt == c_CW'(WIDTH));
    assign w_ebit     = r_e[r_idx];
    assign w_idx_zero = (r_idx == '0);
    assign w_mul_st   = (r_state == S_PRE_M) || (r_state == S_PRE_A) || (r_state == S_SQR)
                     || (r_state == S_MUL)   || (r_state == S_POST);

    // T stays below 2P, so T + B + P fits in WIDTH+3 bits before the halving.
    assign w_sum    = {1'b0, r_t} + (w_abit ? {3'b000, w_op_b} : '0);
    assign w_odd    = w_sum + (w_sum[0] ? {3'b000, r_p} : '0);
    assign w_t_next = w_odd[WIDTH+2:1];
    assign w_ge     = (r_t >= {2'b00, r_p});
    assign w_t_sub  = r_t - {2'b00, r_p};
    assign w_res    = w_ge ? w_t_sub[WIDTH-1:0] : r_t[WIDTH-1:0];
    assign w_unused = ^{w_odd[0], w_t_sub[WIDTH+1:WIDTH]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_load    = 1'b0;
        w_a_we    = 1'b0;
        w_mb_we   = 1'b0;
        w_idx_dec = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_load    = 1'b1;
                    w_state_n = p[0] ? S_PRE_M : S_DONE;
                end
            end
            S_PRE_M: begin
                if (w_last) begin
                    w_mb_we   = 1'b1;
                    w_state_n = S_PRE_A;
                end
            end
            S_PRE_A: begin
                if (w_last) begin
                    w_a_we    = 1'b1;
                    w_state_n = S_SQR;
                end
            end
            S_SQR: begin
                if (w_last) begin
                    w_a_we = 1'b1;
                    if ((CONST_TIME != 0) || w_ebit) begin
                        w_state_n = S_MUL;
                    end else begin
                        w_idx_dec = 1'b1;
                        w_state_n = w_idx_zero ? S_POST : S_SQR;
                    end
                end
            end
            S_MUL: begin
                // In constant-time mode a zero exponent bit still multiplies; the product is dropped.
                if (w_last) begin
                    w_a_we    = w_ebit;
                    w_idx_dec = 1'b1;
                    w_state_n = w_idx_zero ? S_POST : S_SQR;
                end
            end
            S_POST: begin
                if (w_last) begin
                    w_a_we    = 1'b1;
                    w_state_n = S_DONE;
                end
            end
            S_DONE:  w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase
        if (abort && w_mul_st) begin
            w_state_n = S_IDLE;
            w_a_we    = 1'b0;
            w_mb_we   = 1'b0;
            w_idx_dec = 1'b0;
        end
    end

    assign w_busy_n = (w_state_n == S_PRE_M) || (w_state_n == S_PRE_A) || (w_state_n == S_SQR)
                   || (w_state_n == S_MUL)   || (w_state_n == S_POST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_p    <= '0;
            r_e    <= '0;
            r_m    <= '0;
            r_r2   <= '0;
            r_a    <= '0;
            r_mb   <= '0;
            r_t    <= '0;
            r_cnt  <= '0;
            r_idx  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_c    <= '0;
        end else begin
            r_done <= (w_state_n == S_DONE);
            r_busy <= w_busy_n;
            if (w_load) begin
                r_p   <= p;
                r_e   <= e;
                r_m   <= m;
                r_r2  <= r2;
                r_t   <= '0;
                r_cnt <= '0;
                r_idx <= c_IW'(WIDTH - 1);
                r_err <= ~p[0];
                if (!p[0]) begin
                    r_c <= '0;
                end
            end else if (w_mul_st) begin
                if (w_last) begin
                    r_t   <= '0;
                    r_cnt <= '0;
                end else begin
                    r_t   <= w_t_next;
                    r_cnt <= r_cnt + c_CW'(1);
                end
            end
            if (w_a_we) begin
                r_a <= w_res;
            end
            if (w_mb_we) begin
                r_mb <= w_res;
            end
            if (w_idx_dec) begin
                r_idx <= r_idx - c_IW'(1);
            end
            // The POST product goes straight to c so it is valid alongside done.
            if ((r_state == S_POST) && (w_state_n == S_DONE)) begin
                r_c <= w_res;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rsa_modexp_mont.sv
`default_nettype none
// ============================================================================
// Module   : tb_rsa_modexp_mont
// Brief    : Directed-vector and reference-model bench for rsa_modexp_mont.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rsa_modexp_mont;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [7:0]  p8, e8, m8, r2_8;
    logic        start_a, abort_a, busy_a, done_a, err_a;
    logic [7:0]  c_a;
    logic        start_b, abort_b, busy_b, done_b, err_b;
    logic [7:0]  c_b;
    logic [15:0] p16, e16, m16, r2_16;
    logic        start_c, abort_c, busy_c, done_c, err_c;
    logic [15:0] c_c;

    int n_cmp = 0;
    int n_bad = 0;

    rsa_modexp_mont #(.WIDTH(8), .CONST_TIME(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
        .p(p8), .e(e8), .m(m8), .r2(r2_8),
        .busy(busy_a), .done(done_a), .err(err_a), .c(c_a)
    );

    rsa_modexp_mont #(.WIDTH(8), .CONST_TIME(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
        .p(p8), .e(e8), .m(m8), .r2(r2_8),
        .busy(busy_b), .done(done_b), .err(err_b), .c(c_b)
    );

    rsa_modexp_mont #(.WIDTH(16), .CONST_TIME(1)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .abort(abort_c),
        .p(p16), .e(e16), .m(m16), .r2(r2_16),
        .busy(busy_c), .done(done_c), .err(err_c), .c(c_c)
    );

    typedef struct {
        int          s;
        logic [63:0] p, e, m, r2, c;
        int          lat;
        logic        err;
    } vec_t;

    vec_t vt [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic get_done(input int s);
        return (s == 0) ? done_a : (s == 1) ? done_b : done_c;
    endfunction

    function automatic logic get_busy(input int s);
        return (s == 0) ? busy_a : (s == 1) ? busy_b : busy_c;
    endfunction

    function automatic logic get_err(input int s);
        return (s == 0) ? err_a : (s == 1) ? err_b : err_c;
    endfunction

    function automatic logic [63:0] get_c(input int s);
        return (s == 0) ? {56'd0, c_a} : (s == 1) ? {56'd0, c_b} : {48'd0, c_c};
    endfunction

    function automatic logic [63:0] ref_exp(input logic [63:0] p, input logic [63:0] e,
                                            input logic [63:0] m, input int w);
        logic [63:0] r;
        r = 64'd1 % p;
        for (int i = w - 1; i >= 0; i--) begin
            r = (r * r) % p;
            if (e[i]) r = (r * m) % p;
        end
        return r;
    endfunction

    function automatic int ref_lat(input int s, input logic [63:0] e);
        int w, pc;
        w  = (s == 2) ? 16 : 8;
        pc = 0;
        for (int i = 0; i < w; i++) pc += int'(e[i]);
        return (s == 1) ? (w + 3 + pc) * (w + 1) + 1 : (2 * w + 3) * (w + 1) + 1;
    endfunction

    task automatic drive(input int s, input logic [63:0] p, input logic [63:0] e,
                         input logic [63:0] m, input logic [63:0] r2);
        if (s == 2) begin
            p16 = p[15:0]; e16 = e[15:0]; m16 = m[15:0]; r2_16 = r2[15:0];
        end else begin
            p8 = p[7:0]; e8 = e[7:0]; m8 = m[7:0]; r2_8 = r2[7:0];
        end
    endtask

    task automatic set_start(input int s, input logic v);
        if (s == 0) start_a = v;
        else if (s == 1) start_b = v;
        else start_c = v;
    endtask

    // Starts one operation and waits (bounded) for done; lat counts cycles from the sample cycle.
    task automatic run_op(input int s, input logic [63:0] p, input logic [63:0] e,
                          input logic [63:0] m, input logic [63:0] r2,
                          output int lat, output logic [63:0] c, output logic err,
                          output logic busy1);
        drive(s, p, e, m, r2);
        set_start(s, 1'b1);
        @(posedge clk); #1;
        set_start(s, 1'b0);
        busy1 = get_busy(s);
        lat   = 1;
        while (!get_done(s) && lat < 3000) begin
            @(posedge clk); #1;
            lat++;
        end
        c   = get_c(s);
        err = get_err(s);
        @(posedge clk); #1;
        check("done_single_pulse", {63'd0, get_done(s)}, 64'd0);
    endtask

    initial begin
        int          lat, n, ndone;
        logic [63:0] cr, pr, er, mr, r2r;
        logic        errr, b1;

        // 9 has order 5 mod 11 and order 3 mod 13, both dividing 255, so 9^255 mod 143 = 1.
        vt[0]  = '{0, 143,   7, 9, 42, 48, 172, 1'b0};
        vt[1]  = '{0, 143,   0, 9, 42,  1, 172, 1'b0};
        vt[2]  = '{0, 143, 255, 9, 42,  1, 172, 1'b0};
        vt[3]  = '{1, 143,   7, 9, 42, 48, 127, 1'b0};
        vt[4]  = '{1, 143,   0, 9, 42,  1, 100, 1'b0};
        vt[5]  = '{0, 144,   7, 9,  0,  0,   1, 1'b1};
        vt[6]  = '{0, 143,   7, 9, 42, 48, 172, 1'b0};
        vt[7]  = '{0,   1,   5, 0,  0,  0, 172, 1'b0};
        vt[8]  = '{0, 143,   5, 0, 42,  0, 172, 1'b0};
        vt[9]  = '{1, 143, 255, 9, 42,  1, 172, 1'b0};
        vt[10] = '{0,  11,   4, 3,  9,  4, 172, 1'b0};

        rst = 1'b1;
        start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
        start_c = 1'b0; abort_c = 1'b0;
        drive(0, 0, 0, 0, 0);
        drive(2, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {63'd0, busy_a}, 64'd0);
        check("reset_done", {63'd0, done_a}, 64'd0);
        check("reset_err",  {63'd0, err_a},  64'd0);
        check("reset_c",    {56'd0, c_a},    64'd0);
        check("reset_c16",  {48'd0, c_c},    64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            run_op(vt[i].s, vt[i].p, vt[i].e, vt[i].m, vt[i].r2, lat, cr, errr, b1);
            check($sformatf("vec%0d_c", i),     cr,                  vt[i].c);
            check($sformatf("vec%0d_lat", i),   64'(lat),            64'(vt[i].lat));
            check($sformatf("vec%0d_err", i),   {63'd0, errr},       {63'd0, vt[i].err});
            check($sformatf("vec%0d_busy1", i), {63'd0, b1},         {63'd0, ~vt[i].err});
        end

        // A second start mid-operation must not disturb the latched operands.
        drive(0, 143, 7, 9, 42);
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        n = 1;
        while (n < 50) begin @(posedge clk); #1; n++; end
        drive(0, 11, 3, 2, 9);
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        n++;
        while (!done_a && n < 400) begin @(posedge clk); #1; n++; end
        check("ignore_start_lat", 64'(n), 64'd172);
        check("ignore_start_c", {56'd0, c_a}, 64'd48);
        @(posedge clk); #1;

        // Abort at cycle 80 of an operation.
        drive(0, 143, 3, 2, 42);
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        n = 1;
        while (n < 80) begin @(posedge clk); #1; n++; end
        abort_a = 1'b1;
        @(posedge clk); #1;
        abort_a = 1'b0;
        check("abort_busy", {63'd0, busy_a}, 64'd0);
        ndone = 0;
        repeat (200) begin @(posedge clk); #1; if (done_a) ndone++; end
        check("abort_no_done", 64'(ndone), 64'd0);
        check("abort_c_kept", {56'd0, c_a}, 64'd48);
        check("abort_err_kept", {63'd0, err_a}, 64'd0);

        // Abort and start together while idle: abort wins.
        drive(0, 143, 7, 9, 42);
        start_a = 1'b1;
        abort_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        abort_a = 1'b0;
        check("abort_start_busy", {63'd0, busy_a}, 64'd0);
        ndone = 0;
        repeat (200) begin @(posedge clk); #1; if (done_a) ndone++; end
        check("abort_start_no_done", 64'(ndone), 64'd0);

        run_op(0, 143, 3, 9, 42, lat, cr, errr, b1);
        check("after_abort_c", cr, 64'd14);
        check("after_abort_lat", 64'(lat), 64'd172);

        // Synchronous reset at cycle 60 of an operation.
        drive(0, 143, 7, 9, 42);
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        n = 1;
        while (n < 60) begin @(posedge clk); #1; n++; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_busy", {63'd0, busy_a}, 64'd0);
        check("midrst_done", {63'd0, done_a}, 64'd0);
        check("midrst_err",  {63'd0, err_a},  64'd0);
        check("midrst_c",    {56'd0, c_a},    64'd0);
        ndone = 0;
        repeat (200) begin @(posedge clk); #1; if (done_a) ndone++; end
        check("midrst_no_done", 64'(ndone), 64'd0);

        // Random odd moduli against the arithmetic reference model.
        for (int k = 0; k < 21; k++) begin
            int s;
            s = (k < 8) ? 0 : (k < 16) ? 1 : 2;
            if (s == 2) begin
                pr  = 64'(2 * $urandom_range(1, 32767) + 1);
                er  = 64'($urandom_range(0, 65535));
                r2r = (64'd1 << 32) % pr;
            end else begin
                pr  = 64'(2 * $urandom_range(1, 127) + 1);
                er  = 64'($urandom_range(0, 255));
                r2r = (64'd1 << 16) % pr;
            end
            mr = 64'($urandom_range(0, 32'(pr) - 1));
            run_op(s, pr, er, mr, r2r, lat, cr, errr, b1);
            check($sformatf("rand%0d_c(p=%0d e=%0d m=%0d)", k, pr, er, mr), cr,
                  ref_exp(pr, er, mr, (s == 2) ? 16 : 8));
            check($sformatf("rand%0d_lat", k), 64'(lat), 64'(ref_lat(s, er)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
